// File: rtl/tube_scan_ctrl_pkg.sv
// Shared register map, control-bit layout and segment table for the tube scan controller.
package tube_scan_ctrl_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned NIB_W    = 4;
    localparam int unsigned SEG_W    = 8;
    localparam int unsigned DIGITS   = 4;
    localparam int unsigned BLANK_W  = 8;

    // Word offsets within the device
    typedef enum logic [ADDR_W-1:0] {
        REG_DATA   = 2'd0,
        REG_TUBE2  = 2'd1,
        REG_CTRL   = 2'd2,
        REG_STATUS = 2'd3
    } reg_addr_e;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_BLANK_LSB  = 8;
    localparam int unsigned CTRL_BLANK2_BIT = 16;

    // STATUS bit positions
    localparam int unsigned STAT_PEND_BIT   = 2;

    // Segment pattern for a dark digit (active-low, dp off)
    localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;

    // Active-low {dp,g..a} patterns; entry n lives at bits [8n+7:8n]
    localparam logic [16*SEG_W-1:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Live control register contents
    typedef struct packed {
        logic               blank2;
        logic [BLANK_W-1:0] blank;
        logic               en;
    } ctrl_t;

endpackage

// File: rtl/hex7seg_decode.sv
// Nibble to active-low 7-segment pattern, forced dark when blanked.
module hex7seg_decode
    import tube_scan_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] nibble_i,
    input  logic             blank_i,
    output logic [SEG_W-1:0] seg_o
);

    // Table lookup, overridden by blank
    always_comb begin
        seg_o = SEG_OFF;
        if (!blank_i) begin
            seg_o = SEG_LUT[{nibble_i, 3'b000} +: SEG_W];
        end
    end

endmodule

// File: rtl/tube_scan_ctrl.sv
// Bus-mapped scan controller for three 7-segment tubes with frame-synchronous data commit.
module tube_scan_ctrl
    import tube_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic              clk_in,
    input  logic              sys_rstn,
    input  logic [1:0]        addr,
    input  logic              we,
    input  logic [31:0]       wd,
    output logic [31:0]       rd,
    output logic [7:0]        digital_tube0,
    output logic [3:0]        digital_tube_sel0,
    output logic [7:0]        digital_tube1,
    output logic [3:0]        digital_tube_sel1,
    output logic [7:0]        digital_tube2,
    output logic              digital_tube_sel2
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam ctrl_t CTRL_RST = '{blank2: 1'b0, blank: '0, en: 1'b1};

    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] active_q, active_d;
    logic              pending_q, pending_d;
    logic [NIB_W-1:0]  tube2_q, tube2_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [1:0]        idx_q, idx_d;

    logic [SEG_W-1:0]  seg0_q, seg0_d;
    logic [SEG_W-1:0]  seg1_q, seg1_d;
    logic [SEG_W-1:0]  seg2_q, seg2_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic              sel2_q, sel2_d;

    logic              tick_c;
    logic              commit_c;
    logic [NIB_W-1:0]  nib0_c, nib1_c;
    logic              blank0_c, blank1_c;
    logic [SEG_W-1:0]  dec0_c, dec1_c, dec2_c;

    // Scan timing and commit qualification
    always_comb begin
        tick_c   = ctrl_q.en && (presc_q == PRE_LAST);
        commit_c = !ctrl_q.en || (tick_c && (idx_q == 2'd3) && pending_q);
    end

    // Register file, prescaler and double-buffer next state
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        tube2_d   = tube2_q;
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        idx_d     = idx_q;

        if (!ctrl_q.en) begin
            presc_d = '0;
            idx_d   = '0;
        end else if (tick_c) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end

        // Commit reads the pre-write shadow so a colliding write stays pending
        if (commit_c) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        if (we) begin
            case (reg_addr_e'(addr))
                REG_DATA: begin
                    shadow_d  = wd;
                    pending_d = 1'b1;
                end
                REG_TUBE2: tube2_d = wd[NIB_W-1:0];
                REG_CTRL: begin
                    ctrl_d.en     = wd[CTRL_EN_BIT];
                    ctrl_d.blank  = wd[CTRL_BLANK_LSB +: BLANK_W];
                    ctrl_d.blank2 = wd[CTRL_BLANK2_BIT];
                end
                default: ;
            endcase
        end
    end

    // Current digit selection for both four-digit tubes
    always_comb begin
        nib0_c   = active_q[{idx_q, 2'b00} +: NIB_W];
        nib1_c   = active_q[{1'b1, idx_q, 2'b00} +: NIB_W];
        blank0_c = ctrl_q.blank[{1'b0, idx_q}];
        blank1_c = ctrl_q.blank[{1'b1, idx_q}];
    end

    hex7seg_decode u_dec0 (
        .nibble_i (nib0_c),
        .blank_i  (blank0_c),
        .seg_o    (dec0_c)
    );

    hex7seg_decode u_dec1 (
        .nibble_i (nib1_c),
        .blank_i  (blank1_c),
        .seg_o    (dec1_c)
    );

    hex7seg_decode u_dec2 (
        .nibble_i (tube2_q),
        .blank_i  (ctrl_q.blank2),
        .seg_o    (dec2_c)
    );

    // Display drive next state; everything dark while disabled
    always_comb begin
        seg0_d = SEG_OFF;
        seg1_d = SEG_OFF;
        seg2_d = SEG_OFF;
        sel_d  = '0;
        sel2_d = 1'b0;
        if (ctrl_q.en) begin
            seg0_d = dec0_c;
            seg1_d = dec1_c;
            seg2_d = dec2_c;
            sel_d  = DIGITS'(1) << idx_q;
            sel2_d = 1'b1;
        end
    end

    // Control and data state
    always_ff @(posedge clk_in) begin
        if (!sys_rstn) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            tube2_q   <= '0;
            ctrl_q    <= CTRL_RST;
            presc_q   <= '0;
            idx_q     <= '0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            tube2_q   <= tube2_d;
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk_in) begin
        if (!sys_rstn) begin
            seg0_q <= SEG_OFF;
            seg1_q <= SEG_OFF;
            seg2_q <= SEG_OFF;
            sel_q  <= '0;
            sel2_q <= 1'b0;
        end else begin
            seg0_q <= seg0_d;
            seg1_q <= seg1_d;
            seg2_q <= seg2_d;
            sel_q  <= sel_d;
            sel2_q <= sel2_d;
        end
    end

    assign digital_tube0     = seg0_q;
    assign digital_tube1     = seg1_q;
    assign digital_tube2     = seg2_q;
    assign digital_tube_sel0 = sel_q;
    assign digital_tube_sel1 = sel_q;
    assign digital_tube_sel2 = sel2_q;

    // Combinational read mux, undefined bits read zero
    always_comb begin
        rd = '0;
        case (reg_addr_e'(addr))
            REG_DATA:   rd = shadow_q;
            REG_TUBE2:  rd[NIB_W-1:0] = tube2_q;
            REG_CTRL: begin
                rd[CTRL_EN_BIT]                = ctrl_q.en;
                rd[CTRL_BLANK_LSB +: BLANK_W]  = ctrl_q.blank;
                rd[CTRL_BLANK2_BIT]            = ctrl_q.blank2;
            end
            REG_STATUS: begin
                rd[1:0]           = idx_q;
                rd[STAT_PEND_BIT] = pending_q;
            end
            default: rd = '0;
        endcase
    end

endmodule
